rom_reader: RTL and testbench



---
 rtl/rom_reader_pkg.sv | 16 +
 rtl/rom_reader_if.sv | 26 ++
 rtl/rom_reader_mod_counter.sv | 25 ++
 rtl/rom_reader.sv | 134 +++++++++++++
 tb/tb_rom_reader.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/rom_reader_pkg.sv
// Shared constants and state encoding for the ROM sweep sequencer.
// The ROM geometry constants are also used by the lookup ROM itself.
package rom_reader_pkg;

  localparam int ROM_DEPTH = 10;
  localparam int ROM_AW    = 4;
  localparam int ROM_DW    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rom_reader_if.sv
// ROM port plus valid/ready output stream between the sequencer (master)
// and the ROM / downstream consumer (slave).
interface rom_reader_if #(
  parameter int AW = 4,
  parameter int DW = 10
);

  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (
    output rom_addr, rom_cs, out_data, out_valid, out_last,
    input  rom_data, out_ready
  );

  modport slave (
    input  rom_addr, rom_cs, out_data, out_valid, out_last,
    output rom_data, out_ready
  );

endinterface

// File: rtl/rom_reader_mod_counter.sv
// Word index counter: synchronous clear, increment enable, explicit wrap
// at DEPTH-1 so addresses at or beyond DEPTH never appear.
module mod_counter #(
  parameter int AW    = 4,
  parameter int DEPTH = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] idx,
  output logic          tc
);

  assign tc = (idx == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= tc ? '0 : idx + AW'(1);
    end
  end

endmodule

// File: rtl/rom_reader.sv
// Sweeps ROM addresses 0..DEPTH-1 on a start pulse and streams each word
// out over valid/ready, with registered ROM address and chip-select.
module rom_reader
  import rom_reader_pkg::*;
#(
  parameter int DEPTH = ROM_DEPTH,
  parameter int AW    = ROM_AW,
  parameter int DW    = ROM_DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         loop_en,
  output logic         busy,
  output logic         done,
  rom_reader_if.master bus
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] idx;
  logic          last_idx;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          capture;
  logic          retire;
  logic          kill;
  logic [DW-1:0] rom_word;

  assign rom_word = bus.rom_data;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  mod_counter #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .idx (idx),
    .tc  (last_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort overrides every transition, including a same-cycle handshake.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    kill      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = FETCH;
          cnt_clr   = 1'b1;
        end
      end
      FETCH: begin
        state_nxt = SEND;
        capture   = 1'b1;
      end
      SEND: begin
        if (bus.out_ready) begin
          if (!last_idx) begin
            state_nxt = FETCH;
            cnt_inc   = 1'b1;
          end else if (loop_en) begin
            state_nxt = FETCH;
            cnt_clr   = 1'b1;
          end else begin
            state_nxt = DONE;
            retire    = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      capture   = 1'b0;
      retire    = 1'b0;
      kill      = 1'b1;
    end
  end

  // rom_addr only moves on the edge that enters FETCH, when rom_cs rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rom_addr  <= '0;
      bus.rom_cs    <= 1'b0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      if (cnt_clr || cnt_inc) begin
        bus.rom_addr  <= cnt_clr ? '0 : idx + AW'(1);
        bus.rom_cs    <= 1'b1;
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end
      if (capture) begin
        bus.out_data  <= rom_word;
        bus.out_valid <= 1'b1;
        bus.out_last  <= last_idx;
        bus.rom_cs    <= 1'b0;
      end
      if (retire || kill) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
        bus.rom_cs    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader: sweeps, backpressure, looping, abort,
// start-while-busy and mid-sweep reset against a ROM holding word i at i.
module tb_rom_reader;
  import rom_reader_pkg::*;

  localparam int DEPTH = ROM_DEPTH;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic start   = 1'b0;
  logic abort   = 1'b0;
  logic loop_en = 1'b0;
  logic busy;
  logic done;

  int check_count = 0;
  int fail_count  = 0;

  logic [ROM_DW-1:0] rom [16];

  rom_reader_if #(.AW(ROM_AW), .DW(ROM_DW)) bus ();

  rom_reader #(
    .DEPTH (DEPTH),
    .AW    (ROM_AW),
    .DW    (ROM_DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .loop_en (loop_en),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Deselected or out-of-range reads return all ones so stray captures show up.
  assign bus.rom_data = (bus.rom_cs && bus.rom_addr < ROM_AW'(DEPTH)) ? rom[bus.rom_addr] : 10'h3FF;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic l, input logic r);
    start         = s;
    abort         = a;
    loop_en       = l;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Entered in FETCH of word 0; walks one pass of the sweep.
  task automatic runPass(input int stall_word, input int clear_loop_at, input int abort_word,
                         input int start_word, input bit expect_loop);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("fetch_cs", 32'(bus.rom_cs), 32'd1);
      checkOutput("fetch_addr", 32'(bus.rom_addr), 32'(i));
      checkOutput("fetch_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("fetch_busy", 32'(busy), 32'd1);
      if (i == clear_loop_at) loop_en = 1'b0;
      applyStimulus(i == start_word, 1'b0, loop_en, i != stall_word);
      checkOutput("send_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("send_data", 32'(bus.out_data), 32'(i));
      checkOutput("send_last", 32'(bus.out_last), 32'(i == DEPTH - 1));
      checkOutput("send_cs", 32'(bus.rom_cs), 32'd0);
      if (i == stall_word) begin
        for (int k = 0; k < 5; k++) begin
          applyStimulus(1'b0, 1'b0, loop_en, 1'b0);
          checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
          checkOutput("stall_data", 32'(bus.out_data), 32'(i));
          checkOutput("stall_cs", 32'(bus.rom_cs), 32'd0);
        end
      end
      if (i == abort_word) begin
        applyStimulus(1'b0, 1'b1, loop_en, 1'b1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_cs", 32'(bus.rom_cs), 32'd0);
        checkOutput("abort_last", 32'(bus.out_last), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        applyStimulus(1'b0, 1'b0, loop_en, 1'b1);
        checkOutput("abort_done_after", 32'(done), 32'd0);
        checkOutput("abort_busy_after", 32'(busy), 32'd0);
        return;
      end
      applyStimulus(1'b0, 1'b0, loop_en, 1'b1);
    end
    if (expect_loop) begin
      checkOutput("loop_no_done", 32'(done), 32'd0);
    end else begin
      checkOutput("done_pulse", 32'(done), 32'd1);
      checkOutput("done_busy", 32'(busy), 32'd1);
      checkOutput("done_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("done_last", 32'(bus.out_last), 32'd0);
      applyStimulus(1'b0, 1'b0, loop_en, 1'b1);
      checkOutput("idle_done", 32'(done), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_cs", 32'(bus.rom_cs), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = ROM_DW'(i);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_addr", 32'(bus.rom_addr), 32'd0);
    checkOutput("rst_cs", 32'(bus.rom_cs), 32'd0);
    checkOutput("rst_data", 32'(bus.out_data), 32'd0);
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_last", 32'(bus.out_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("start_abort_busy", 32'(busy), 32'd0);
    checkOutput("start_abort_cs", 32'(bus.rom_cs), 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    runPass(-1, -1, -1, -1, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    runPass(3, -1, -1, -1, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    runPass(-1, -1, -1, -1, 1'b1);
    runPass(-1, 4, -1, -1, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    runPass(-1, -1, 5, -1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    runPass(-1, -1, -1, 2, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("pre_rst_data", 32'(bus.out_data), 32'd1);
    checkOutput("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("mid_rst_addr", 32'(bus.rom_addr), 32'd0);
    checkOutput("mid_rst_cs", 32'(bus.rom_cs), 32'd0);
    checkOutput("mid_rst_data", 32'(bus.out_data), 32'd0);
    checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_last", 32'(bus.out_last), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
